// File: rtl/if_prefetch.sv
// DLX instruction fetch unit: variable-latency imem handshake, DEPTH-entry prefetch
// queue and the IF/ID output register, with decode stall and branch redirect.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  input  logic        branch,
  input  logic [31:0] branch_pc,
  input  logic        stall,
  output logic [0:31] inst_id,
  output logic [31:0] pc_plus_four_id,
  output logic        inst_valid_id
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d, count_nx;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [0:31]   inst_q, inst_d;
  logic [31:0]   ppf_q, ppf_d;
  logic          valid_q, valid_d;

  logic [0:31]   qinst_q [DEPTH];
  logic [31:0]   qppf_q  [DEPTH];

  logic enq, deq, load_out;

  assign enq      = (state_q == ST_REQ) && imem_ack && !branch;
  assign load_out = !stall || !valid_q;
  assign deq      = load_out && (count_q != '0);

  always_comb begin
    count_nx = count_q;
    if (enq && !deq) begin
      count_nx = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_nx = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    count_d = count_nx;
    rd_d    = deq ? rd_q + 1'b1 : rd_q;
    wr_d    = enq ? wr_q + 1'b1 : wr_q;
    inst_d  = inst_q;
    ppf_d   = ppf_q;
    valid_d = valid_q;

    if (load_out) begin
      if (count_q != '0) begin
        inst_d  = qinst_q[rd_q];
        ppf_d   = qppf_q[rd_q];
        valid_d = 1'b1;
      end else begin
        inst_d  = '0;
        valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: if (count_q < FULL) state_d = ST_REQ;
      ST_REQ: begin
        if (enq) begin
          fpc_d   = fpc_q + 32'd4;
          addr_d  = fpc_q + 32'd4;
          state_d = (count_nx < FULL) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_d = ST_REQ;
          addr_d  = fpc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect flushes everything; an unacked request must still complete at its
    // old address, so its response is swallowed in DROP before fetching the target.
    if (branch) begin
      fpc_d   = branch_pc;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
      ppf_d   = ppf_q;
      if ((state_q == ST_IDLE) || imem_ack) begin
        state_d = ST_REQ;
        addr_d  = branch_pc;
      end else begin
        state_d = ST_DROP;
        addr_d  = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      inst_q  <= '0;
      ppf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      inst_q  <= inst_d;
      ppf_q   <= ppf_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      qinst_q[wr_q] <= imem_rdata;
      qppf_q[wr_q]  <= addr_q + 32'd4;
    end
  end

  assign imem_req        = (state_q != ST_IDLE);
  assign imem_addr       = addr_q;
  assign inst_id         = inst_q;
  assign pc_plus_four_id = ppf_q;
  assign inst_valid_id   = valid_q;
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: memory returns word = address; a program-order model checks
// every presented instruction, holds, bubbles and request stability each cycle.
module tb_if_prefetch;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [0:31] imem_rdata = '0;
  logic        branch = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        stall = 1'b0;
  logic [0:31] inst_id;
  logic [31:0] pc_plus_four_id;
  logic        inst_valid_id;

  int checks = 0;
  int errors = 0;
  int unsigned wait_n = 0;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch(branch), .branch_pc(branch_pc), .stall(stall),
    .inst_id(inst_id), .pc_plus_four_id(pc_plus_four_id), .inst_valid_id(inst_valid_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Memory: acks after wait_n extra cycles; reset cancels any pending request.
  initial begin : mem_model
    int unsigned pend;
    pend = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !imem_req) begin
        pend = 0; imem_ack = 1'b0;
      end else if (pend >= wait_n) begin
        imem_ack = 1'b1; imem_rdata = imem_addr; pend = 0;
      end else begin
        imem_ack = 1'b0; pend++;
      end
    end
  end

  // Program-order model: next presented instruction is exp_pc unless held by stall.
  logic [31:0] exp_pc;
  logic        have_prev, p_valid, p_stall, p_branch, p_req, p_ack;
  logic [31:0] p_bpc, p_addr, p_inst, p_ppf;

  initial begin : compare
    have_prev = 1'b0;
    exp_pc    = RESET_PC;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_prev = 1'b0;
        exp_pc    = RESET_PC;
      end else begin
        if (have_prev && p_branch) exp_pc = p_bpc;
        if (inst_valid_id) begin
          if (have_prev && p_valid && p_stall && !p_branch) begin
            chk("hold_inst", inst_id, p_inst);
            chk("hold_ppf", pc_plus_four_id, p_ppf);
          end else begin
            chk("seq_inst", inst_id, exp_pc);
            chk("seq_ppf", pc_plus_four_id, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
          end
        end else begin
          chk("bubble_inst", inst_id, 32'h0);
          if (have_prev) chk("bubble_ppf", pc_plus_four_id, p_ppf);
        end
        if (have_prev && p_branch) chk("branch_bubble", {31'b0, inst_valid_id}, 32'd0);
        if (have_prev && p_req && !p_ack) begin
          chk("req_held", {31'b0, imem_req}, 32'd1);
          chk("addr_held", imem_addr, p_addr);
        end
        have_prev = 1'b1;
        p_valid = inst_valid_id; p_stall = stall; p_branch = branch; p_bpc = branch_pc;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        p_inst = inst_id; p_ppf = pc_plus_four_id;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int acks, found, n, n_pres, seen, want_zero;
  logic pv, ps;
  logic [39:0] pat;

  initial begin : stim
    pat = 40'h07C303F040;

    // Zero-wait memory from reset
    wait_n = 0;
    do_reset();
    sample();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, inst_valid_id}, 32'd0);
    chk("rst_inst", inst_id, 32'h0);
    chk("rst_ppf", pc_plus_four_id, 32'h0);
    next_cycle(); sample();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    next_cycle(); sample();
    chk("c2_valid", {31'b0, inst_valid_id}, 32'd0);
    next_cycle(); sample();
    chk("c3_valid", {31'b0, inst_valid_id}, 32'd1);
    chk("c3_inst", inst_id, 32'h0);
    chk("c3_ppf", pc_plus_four_id, 32'h4);
    next_cycle(); sample();
    chk("c4_inst", inst_id, 32'h4);
    next_cycle(); sample();
    chk("c5_inst", inst_id, 32'h8);

    // Stall for 10 cycles: queue fills (1 entry already buffered -> 3 more acks)
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); stall = 1'b1;
      sample();
      if (imem_req && imem_ack) acks++;
    end
    chk("stall_acks", acks, 32'd3);
    chk("stall_req_low", {31'b0, imem_req}, 32'd0);
    chk("stall_hold_inst", inst_id, 32'hC);
    next_cycle(); stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("release_valid", {31'b0, inst_valid_id}, 32'd1);
      if (i == 1) chk("release_inst", inst_id, 32'h10);
      next_cycle();
    end

    // Three wait states per request
    do_reset();
    wait_n = 3;
    sample();
    chk("rst3_req", {31'b0, imem_req}, 32'd0);
    for (int c = 1; c < 18; c++) begin
      next_cycle(); sample();
      if (c >= 6) chk("ws_valid", {31'b0, inst_valid_id}, ((c - 6) % 4 == 0) ? 32'd1 : 32'd0);
      if (c == 10) chk("ws_inst", inst_id, 32'h4);
    end

    // Branch while the request for 0x20 is pending
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      next_cycle(); sample();
      if (imem_req && imem_addr == 32'h20) found = 1;
    end
    chk("found_req20", found, 32'd1);
    next_cycle(); branch = 1'b1; branch_pc = 32'h100;
    sample();
    chk("inflight_noack", {31'b0, imem_ack}, 32'd0);
    next_cycle(); branch = 1'b0;
    sample();
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h20);
    next_cycle(); sample();
    next_cycle(); sample();
    chk("redirect_addr", imem_addr, 32'h100);
    n = 0;
    do begin
      next_cycle(); sample(); n++;
    end while (!inst_valid_id && n < 20);
    chk("target_valid", {31'b0, inst_valid_id}, 32'd1);
    chk("target_inst", inst_id, 32'h100);
    chk("target_ppf", pc_plus_four_id, 32'h104);

    // Reset mid-request, then branch + ack + stall in the same cycle
    do_reset();
    wait_n = 0;
    sample();
    chk("rst4_req", {31'b0, imem_req}, 32'd0);
    chk("rst4_addr", imem_addr, RESET_PC);
    repeat (5) begin next_cycle(); sample(); end
    chk("pre_coinc_inst", inst_id, 32'h8);
    next_cycle(); stall = 1'b1; branch = 1'b1; branch_pc = 32'h200;
    sample();
    chk("coinc_ack", {31'b0, imem_ack}, 32'd1);
    next_cycle(); stall = 1'b0; branch = 1'b0;
    sample();
    chk("coinc_valid", {31'b0, inst_valid_id}, 32'd0);
    chk("coinc_inst", inst_id, 32'h0);
    chk("coinc_addr", imem_addr, 32'h200);
    next_cycle(); sample();
    chk("coinc_empty", {31'b0, inst_valid_id}, 32'd0);
    next_cycle(); sample();
    chk("coinc_t3_valid", {31'b0, inst_valid_id}, 32'd1);
    chk("coinc_t3_inst", inst_id, 32'h200);
    chk("coinc_t3_ppf", pc_plus_four_id, 32'h204);

    // Address wrap and pointer wrap with an irregular stall pattern
    next_cycle(); branch = 1'b1; branch_pc = 32'hFFFF_FFF0;
    sample();
    seen = 0; n_pres = 0; want_zero = 0; pv = 1'b0; ps = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle(); branch = 1'b0; stall = pat[i];
      sample();
      if (inst_valid_id && !(pv && ps)) begin
        n_pres++;
        if (want_zero == 1) begin
          chk("wrap_next", inst_id, 32'h0);
          want_zero = 2;
        end
        if (inst_id == 32'hFFFF_FFFC && seen == 0) begin
          seen = 1;
          want_zero = 1;
          chk("wrap_ppf", pc_plus_four_id, 32'h0);
        end
      end
      pv = inst_valid_id; ps = stall;
    end
    chk("wrap_seen", seen, 32'd1);
    chk("wrap_count", (n_pres >= 3 * DEPTH) ? 32'd1 : 32'd0, 32'd1);
    next_cycle(); stall = 1'b0;
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
